// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the RAM1 access initiator: FSM states, grant IDs, bus widths.
`timescale 1ns/1ps
package mem_access_ctrl_pkg;

  localparam int RAM_AW = 18;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

endpackage

// File: rtl/mem_access_ctrl.sv
// Arbitrates IF and MEM requests onto the single RAM1 port, sequencing each access
// as IDLE -> ACCESS (held WAIT_CYCLES extra) -> RESP with a registered done pulse.
`timescale 1ns/1ps
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int         WAIT_CYCLES = 0,
  parameter logic [1:0] ADDR_HI     = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_stall,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

  state_t     state, state_next;
  logic [2:0] wait_cnt;
  // last_grant also identifies the owner of the access currently in flight
  logic       last_grant;
  logic       grant_next;
  logic       any_req;

  assign any_req   = if_req | mem_req;
  assign busy      = (state != IDLE);
  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_req & ~mem_done;

  // MEM wins a tie unless it won the previous grant, so neither side starves
  always_comb begin
    grant_next = GRANT_IF;
    if (mem_req && (!if_req || last_grant == GRANT_IF)) grant_next = GRANT_MEM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = ACCESS;
      ACCESS:  if (wait_cnt == 3'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= 3'd0;
      last_grant <= GRANT_IF;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_done    <= 1'b0;
      mem_done   <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            last_grant <= grant_next;
            wait_cnt   <= WAIT_INIT;
            if (grant_next == GRANT_MEM) begin
              ram_addr  <= {ADDR_HI, mem_addr};
              ram_wdata <= mem_wdata;
              ram_we    <= mem_we;
            end else begin
              ram_addr <= {ADDR_HI, if_addr};
              ram_we   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
          end else begin
            ram_we <= 1'b0;
            if (last_grant == GRANT_MEM) begin
              mem_done <= 1'b1;
              if (!ram_we) mem_rdata <= ram_rdata;
            end else begin
              if_done  <= 1'b1;
              if_rdata <= ram_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the single-port RAM1 controller: arbitrates instruction-fetch (IF) and data (MEM) requests onto one SRAM port.
- Sequences each access over whole clock periods and returns read data with a done pulse.
- Raises per-port stall so the pipeline freezes while an access is outstanding.
- Sits between the IF/MEM pipeline stages and the RAM1 controller.

Parameters:
- WAIT_CYCLES, 0, extra cycles the access phase is held beyond the minimum one cycle, for slow SRAM (0..7).
- ADDR_HI, 2'b00, constant upper two bits prepended to the 16-bit CPU address to form the 18-bit RAM address.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  IF read request; held high until if_done.
- if_addr  in  16  IF word address.
- if_rdata  out  16  fetched word; valid in the if_done cycle, held until the next IF completion.
- if_done  out  1  one-cycle completion pulse for IF.
- if_stall  out  1  high when if_req=1 and if_done=0.
- mem_req  in  1  MEM request; held high until mem_done.
- mem_we  in  1  1 = write, 0 = read.
- mem_addr  in  16  MEM word address.
- mem_wdata  in  16  write data.
- mem_rdata  out  16  read data; valid in the mem_done cycle, held until the next MEM read completes.
- mem_done  out  1  one-cycle completion pulse for MEM.
- mem_stall  out  1  high when mem_req=1 and mem_done=0.
- ram_addr  out  18  address to the RAM1 controller.
- ram_wdata  out  16  write data to the RAM1 controller.
- ram_we  out  1  1 = write cycle, 0 = read cycle.
- ram_rdata  in  16  data captured by the RAM1 controller on the falling edge of the access cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: state IDLE, ram_we=0, ram_addr=0, ram_wdata=0, if_rdata=0, mem_rdata=0, both done=0, busy=0, last_grant=IF.
- ram_we is registered and forced to 0 asynchronously by rst, so no spurious write is possible.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any request is present, grant one.
  - Latch ram_addr={ADDR_HI,addr}, ram_wdata, and ram_we (mem_we for MEM, 0 for IF).
  - Load wait_cnt=WAIT_CYCLES and go to ACCESS.
- Arbitration when both requests are present: grant MEM, except grant IF if last_grant was MEM. This alternation prevents starvation.
- A lone request is granted directly. last_grant updates on every grant.
- ACCESS:
  - ram_addr, ram_wdata and ram_we are stable for the whole state.
  - If wait_cnt != 0, decrement it and stay; otherwise go to RESP.
  - On the exit edge, capture ram_rdata into the granted port's rdata if the access was a read; write accesses leave rdata unchanged.
  - Assert that port's done, registered, for exactly the RESP cycle.
  - Set ram_we to 0 on the same edge.
- RESP: done pulse is active; always return to IDLE next cycle. Requesters drop or change req in the done cycle.
- Latency from req seen in IDLE (cycle N) to done: cycle N+2+WAIT_CYCLES. Throughput: one access per 3+WAIT_CYCLES cycles.
- Outside ACCESS, ram_addr holds its last value and ram_we=0; idle cycles are benign reads.
- A request withdrawn mid-access does not abort: the access completes and the done pulse is still issued.
- Inputs sampled only in IDLE; changes during ACCESS/RESP are ignored.
- stall outputs are combinational from req and done.
- Async rst mid-access: immediate return to IDLE, ram_we=0, no done pulse, latched rdata cleared.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - grant IDs GRANT_IF=1'b0, GRANT_MEM=1'b1;
  - RAM_AW=18 and WORD_W=16.
- No sub-module; the arbiter is a few lines inside the FSM.

Test Plan:
- IF read only, WAIT_CYCLES=0:
  - Stimulus: if_addr=16'h0040, ram_rdata model returns 16'h1234.
  - Required: ram_addr=18'h00040 and ram_we=0 during ACCESS; if_done in cycle N+2; if_rdata=16'h1234; if_stall high for cycles N..N+1.
- MEM write:
  - Stimulus: mem_we=1, mem_addr=16'hBF00, mem_wdata=16'hA5A5.
  - Required: ram_we=1 for exactly one cycle with ram_addr=18'h0BF00 and ram_wdata=16'hA5A5; mem_done pulse; mem_rdata unchanged.
- Simultaneous if_req and mem_req held for two accesses:
  - Required order: MEM first (last_grant reset=IF), then IF; each done pulses once; no cycle has ram_we=1 with an IF grant.
- Continuous mem_req and if_req for 4 accesses:
  - Required grants alternate MEM, IF, MEM, IF.
- WAIT_CYCLES=2, MEM read of 16'h0003:
  - Required: ACCESS lasts 3 cycles; mem_done at N+4; data 16'hBEEF captured from ram_rdata.
- rst asserted in the middle of a MEM write's ACCESS cycle:
  - Required: ram_we drops to 0 in the same cycle without waiting for clk; state IDLE; no mem_done.
  - After release, a pending if_req is served normally.
